// File: rtl/audio_pkg.sv
// Shared audio constants, widths and the tone generator state type.
package audio_pkg;

  localparam int PRESCALE_W       = 10;
  localparam int PHASE_W          = 8;
  localparam int CLK_HZ           = 31_500_000;
  localparam int STEPS_PER_PERIOD = 256;

  typedef logic [PRESCALE_W-1:0] prescale_t;
  typedef logic [PHASE_W-1:0]    phase_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } gen_state_t;

endpackage

// File: rtl/tick_divider.sv
// Reloadable modulo-div counter; tick is high on the last count of each div-cycle window.
module tick_divider #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] cnt;
  logic [W-1:0] last;

  // div >= 1 whenever run is high, so the wrap of div-1 at div=0 is never observed
  assign last = div - W'(1);
  assign tick = run && (cnt == last);

  always_ff @(posedge clk) begin
    if (reset || !run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/tone_phase_generator.sv
// Audio phase ramp: one phase step every P clocks, 2**PHASE_W steps per tone period.
// Pitch changes are latched only at the phase wrap so periods are never truncated.
module tone_phase_generator
  import audio_pkg::*;
#(
  parameter int PRESCALE_W = audio_pkg::PRESCALE_W,
  parameter int PHASE_W    = audio_pkg::PHASE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] preScaleValue,
  output logic [PHASE_W-1:0]    phase,
  output logic                  sampleTick,
  output logic                  periodStart,
  output logic                  squareOut,
  output logic                  active
);

  gen_state_t            state_q, state_n;
  logic [PRESCALE_W-1:0] p_q, p_n;
  logic [PHASE_W-1:0]    phase_q, phase_n;
  logic                  tick_q, tick_n;
  logic                  pstart_q, pstart_n;
  logic                  div_run;
  logic                  div_tick;

  // Divider only counts while running and enabled; dropping enable clears it at once
  assign div_run = (state_q == ST_RUN) && enable;

  tick_divider #(
    .W (PRESCALE_W)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .run   (div_run),
    .div   (p_q),
    .tick  (div_tick)
  );

  always_comb begin
    state_n  = state_q;
    p_n      = p_q;
    phase_n  = phase_q;
    tick_n   = 1'b0;
    pstart_n = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && (preScaleValue != '0)) begin
          state_n = ST_RUN;
          p_n     = preScaleValue;
          phase_n = '0;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_n = ST_IDLE;
          phase_n = '0;
        end else if (div_tick) begin
          phase_n = phase_q + PHASE_W'(1);
          tick_n  = 1'b1;
          if (phase_q == '1) begin
            pstart_n = 1'b1;
            p_n      = preScaleValue;
            if (preScaleValue == '0) begin
              state_n = ST_IDLE;
            end
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      p_q      <= '0;
      phase_q  <= '0;
      tick_q   <= 1'b0;
      pstart_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      p_q      <= p_n;
      phase_q  <= phase_n;
      tick_q   <= tick_n;
      pstart_q <= pstart_n;
    end
  end

  assign phase       = phase_q;
  assign sampleTick  = tick_q;
  assign periodStart = pstart_q;
  assign squareOut   = phase_q[PHASE_W-1];
  assign active      = (state_q == ST_RUN);

endmodule
